// File: rtl/pe_row_edge_driver.sv
// West-edge driver/collector for one systolic PE row: streams activations in, buffers drained results out.
// Optional drain watchdog enabled by defining PE_ROW_DRAIN_WATCHDOG_EN.
module pe_row_edge_driver #(
  parameter int DATA_WIDTH    = 16,
  parameter int ROW_PES       = 8,
  parameter int LEN_WIDTH     = 10,
  parameter int DRAIN_TIMEOUT = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [LEN_WIDTH-1:0]  vec_len_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  error_o,
  input  logic [DATA_WIDTH-1:0] s_act_data_i,
  input  logic                  s_act_valid_i,
  output logic                  s_act_ready_o,
  output logic                  clear_all_o,
  output logic [DATA_WIDTH-1:0] act_o,
  output logic                  ACTIVATION_ENABLE_o,
  output logic                  END_SIGNAL_o,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  data_valid_i,
  output logic [DATA_WIDTH-1:0] m_res_data_o,
  output logic                  m_res_valid_o,
  input  logic                  m_res_ready_i
);

  typedef enum logic [2:0] {IDLE, CLEAR, STREAM, DRAIN, FLUSH} state_t;

  localparam int PTR_W = (ROW_PES > 1) ? $clog2(ROW_PES) : 1;
  localparam int CNT_W = $clog2(ROW_PES + 1);

  state_t                state, state_nxt;
  logic [LEN_WIDTH-1:0]  len_q, elem_cnt;
  logic [CNT_W-1:0]      cap_cnt, fifo_cnt;
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [DATA_WIDTH-1:0] mem [ROW_PES];
  logic [DATA_WIDTH-1:0] act_p1;
  logic                  vld_p1, end_p1, done_p1, error_p1;
  logic                  act_xfer, last_xfer, cap, pop, fifo_empty;
  logic                  drain_done, timeout, abort;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(ROW_PES - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign act_xfer   = (state == STREAM) && s_act_valid_i;
  assign last_xfer  = act_xfer && (elem_cnt == len_q - LEN_WIDTH'(1));
  assign cap        = (state == DRAIN) && data_valid_i;
  assign drain_done = cap && (cap_cnt == CNT_W'(ROW_PES - 1));
  assign fifo_empty = (fifo_cnt == '0);
  assign pop        = !fifo_empty && m_res_ready_i;
  // A drain that completes in the same cycle the watchdog fires counts as success.
  assign abort      = timeout && !drain_done;

`ifdef PE_ROW_DRAIN_WATCHDOG_EN
  localparam int WD_W = $clog2(DRAIN_TIMEOUT + 1);
  logic [WD_W-1:0] wd_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              wd_cnt <= '0;
    else if (state != DRAIN) wd_cnt <= '0;
    else                     wd_cnt <= wd_cnt + WD_W'(1);
  end

  assign timeout = (state == DRAIN) && (wd_cnt == WD_W'(DRAIN_TIMEOUT - 1));
`else
  // Constant-false; keeps the FSM identical in both builds.
  assign timeout = (DRAIN_TIMEOUT < 0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_i && (vec_len_i != '0)) state_nxt = CLEAR;
      CLEAR:   state_nxt = STREAM;
      STREAM:  if (last_xfer) state_nxt = DRAIN;
      DRAIN:   if (drain_done) state_nxt = FLUSH;
               else if (abort) state_nxt = IDLE;
      FLUSH:   if (fifo_empty) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy_o        = (state != IDLE);
    clear_all_o   = (state == CLEAR);
    s_act_ready_o = (state == STREAM);
  end

  // Stage p1: activation register into PE0 and job counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q    <= '0;
      elem_cnt <= '0;
      cap_cnt  <= '0;
      act_p1   <= '0;
      vld_p1   <= 1'b0;
      end_p1   <= 1'b0;
      done_p1  <= 1'b0;
      error_p1 <= 1'b0;
    end else begin
      if (state == IDLE && start_i && vec_len_i != '0) len_q <= vec_len_i;
      if (state == CLEAR)  elem_cnt <= '0;
      else if (act_xfer)   elem_cnt <= elem_cnt + LEN_WIDTH'(1);
      if (state == CLEAR)  cap_cnt <= '0;
      else if (cap)        cap_cnt <= cap_cnt + CNT_W'(1);
      if (act_xfer) act_p1 <= s_act_data_i;
      vld_p1   <= act_xfer;
      end_p1   <= last_xfer;
      done_p1  <= (state == FLUSH) && fifo_empty;
      error_p1 <= abort;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else if (abort) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (cap) wr_ptr <= ptr_inc(wr_ptr);
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      fifo_cnt <= fifo_cnt + CNT_W'(cap) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (cap) mem[wr_ptr] <= data_i;
  end

  assign act_o               = act_p1;
  assign ACTIVATION_ENABLE_o = vld_p1;
  assign END_SIGNAL_o        = end_p1;
  assign done_o              = done_p1;
  assign error_o             = error_p1;
  assign m_res_valid_o       = !fifo_empty;
  assign m_res_data_o        = fifo_empty ? '0 : mem[rd_ptr];

endmodule
